mem_bus_arbiter: RTL and testbench

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

---
 rtl/mem_bus_pkg.sv | 14 +
 rtl/rr_pick2.sv | 15 +
 rtl/mem_bus_arbiter.sv | 102 ++++++++++
 tb/tb_mem_bus_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Shared types and defaults for the two-master memory bus arbiter.
// State encoding and bus width defaults live here.
package mem_bus_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker.
// When both request, the one not granted last wins.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       valid,
  output logic       winner
);

  always_comb begin
    valid  = |req;
    winner = (&req) ? ~last_grant : req[1];
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one memory bus between two masters.
// Each transaction is grant, one ACCESS cycle, one RESP cycle.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_done,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_done,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] bus_address,
  output logic              bus_readEnable,
  output logic              bus_writeEnable,
  output logic [DATA_W-1:0] bus_writeData,
  input  logic [DATA_W-1:0] bus_readData,
  output logic              grant_id
);

  state_t            state;
  logic              weLat;
  logic              pickValid;
  logic              pickWinner;
  logic              selWe;
  logic [ADDR_W-1:0] selAddr;
  logic [DATA_W-1:0] selWdata;

  rr_pick2 uPick (
    .req        ({m1_req, m0_req}),
    .last_grant (grant_id),
    .valid      (pickValid),
    .winner     (pickWinner)
  );

  always_comb begin
    selWe    = pickWinner ? m1_we    : m0_we;
    selAddr  = pickWinner ? m1_addr  : m0_addr;
    selWdata = pickWinner ? m1_wdata : m0_wdata;
  end

  // Strobes and done are registered, so they line up with ACCESS/RESP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      weLat           <= 1'b0;
      grant_id        <= 1'b1;
      bus_address     <= '0;
      bus_writeData   <= '0;
      bus_readEnable  <= 1'b0;
      bus_writeEnable <= 1'b0;
      m0_done         <= 1'b0;
      m1_done         <= 1'b0;
      m0_rdata        <= '0;
      m1_rdata        <= '0;
    end else begin
      bus_readEnable  <= 1'b0;
      bus_writeEnable <= 1'b0;
      m0_done         <= 1'b0;
      m1_done         <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pickValid) begin
            grant_id        <= pickWinner;
            weLat           <= selWe;
            bus_address     <= selAddr;
            bus_writeData   <= selWdata;
            bus_readEnable  <= ~selWe;
            bus_writeEnable <= selWe;
            state           <= ACCESS;
          end
        end
        ACCESS: begin
          m0_done <= ~grant_id;
          m1_done <= grant_id;
          if (!weLat) begin
            if (grant_id) m1_rdata <= bus_readData;
            else          m0_rdata <= bus_readData;
          end
          state <= RESP;
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter.
// Directed transactions; monitors pop expectations on strobes and done.
module tb_mem_bus_arbiter;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } busExp_t;

  typedef struct {
    bit          id;
    int          cyc;
    logic [31:0] r0;
    logic [31:0] r1;
    logic [31:0] addr;
  } doneExp_t;

  logic        clk = 0;
  logic        rst = 0;
  logic        m0_req = 0, m1_req = 0;
  logic        m0_we = 0, m1_we = 0;
  logic [31:0] m0_addr = 0, m1_addr = 0;
  logic [31:0] m0_wdata = 0, m1_wdata = 0;
  logic        m0_done, m1_done;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] bus_address;
  logic        bus_readEnable, bus_writeEnable;
  logic [31:0] bus_writeData;
  logic [31:0] bus_readData = 0;
  logic        grant_id;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  busExp_t  busQ[$];
  doneExp_t doneQ[$];

  mem_bus_arbiter dut (
    .clk             (clk),
    .rst             (rst),
    .m0_req          (m0_req),
    .m0_we           (m0_we),
    .m0_addr         (m0_addr),
    .m0_wdata        (m0_wdata),
    .m0_done         (m0_done),
    .m0_rdata        (m0_rdata),
    .m1_req          (m1_req),
    .m1_we           (m1_we),
    .m1_addr         (m1_addr),
    .m1_wdata        (m1_wdata),
    .m1_done         (m1_done),
    .m1_rdata        (m1_rdata),
    .bus_address     (bus_address),
    .bus_readEnable  (bus_readEnable),
    .bus_writeEnable (bus_writeEnable),
    .bus_writeData   (bus_writeData),
    .bus_readData    (bus_readData),
    .grant_id        (grant_id)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic pushBus(input bit we, input logic [31:0] a,
                         input logic [31:0] d);
    busExp_t e;
    e.we = we; e.addr = a; e.wdata = d;
    busQ.push_back(e);
  endtask

  task automatic pushDone(input bit id, input int c, input logic [31:0] r0,
                          input logic [31:0] r1, input logic [31:0] a);
    doneExp_t e;
    e.id = id; e.cyc = c; e.r0 = r0; e.r1 = r1; e.addr = a;
    doneQ.push_back(e);
  endtask

  // Invariants every cycle
  always @(negedge clk) begin
    chk("strobe_excl", {63'd0, bus_readEnable & bus_writeEnable}, 64'd0);
    chk("done_excl", {63'd0, m0_done & m1_done}, 64'd0);
  end

  // Bus-side monitor
  always @(negedge clk) begin
    busExp_t b;
    if (rst && (bus_readEnable || bus_writeEnable)) begin
      if (busQ.size() == 0) begin
        total++;
        $display("FAIL bus_unexpected: got addr %h want no strobe",
                 bus_address);
      end else begin
        b = busQ.pop_front();
        chk("bus_we", {63'd0, bus_writeEnable}, {63'd0, b.we});
        chk("bus_addr", {32'd0, bus_address}, {32'd0, b.addr});
        if (b.we)
          chk("bus_wdata", {32'd0, bus_writeData}, {32'd0, b.wdata});
      end
    end
  end

  // Completion monitor
  always @(negedge clk) begin
    doneExp_t d;
    if (m0_done || m1_done) begin
      if (doneQ.size() == 0) begin
        total++;
        $display("FAIL done_unexpected: got m0 %b m1 %b want none",
                 m0_done, m1_done);
      end else begin
        d = doneQ.pop_front();
        chk("done_id", {63'd0, m1_done}, {63'd0, d.id});
        chk("done_cyc", 64'(cyc), 64'(d.cyc));
        chk("m0_rdata", {32'd0, m0_rdata}, {32'd0, d.r0});
        chk("m1_rdata", {32'd0, m1_rdata}, {32'd0, d.r1});
        chk("resp_addr", {32'd0, bus_address}, {32'd0, d.addr});
        chk("resp_strobe",
            {62'd0, bus_readEnable, bus_writeEnable}, 64'd0);
      end
    end
  end

  task automatic masterWait(input bit id, input int n);
    int got = 0;
    int t = 0;
    while (got < n && t < 60) begin
      @(negedge clk);
      t++;
      if (id ? m1_done : m0_done) got++;
    end
    if (got < n) begin
      total++;
      $display("FAIL timeout_m%0d: got %0d dones want %0d", id, got, n);
    end
    @(posedge clk);
    #1;
    if (id) m1_req = 0;
    else    m0_req = 0;
  endtask

  task automatic resetChecks();
    chk("rst_done", {62'd0, m0_done, m1_done}, 64'd0);
    chk("rst_strobe", {62'd0, bus_readEnable, bus_writeEnable}, 64'd0);
    chk("rst_rdata", {m0_rdata, m1_rdata}, 64'd0);
    chk("rst_addr", {32'd0, bus_address}, 64'd0);
    chk("rst_wdata", {32'd0, bus_writeData}, 64'd0);
    chk("rst_grant", {63'd0, grant_id}, 64'd1);
  endtask

  int r;

  initial begin
    repeat (2) @(negedge clk);
    resetChecks();
    rst = 1;
    repeat (2) @(posedge clk);

    // Single m0 read
    #1;
    r = cyc;
    m0_we = 0; m0_addr = 32'h10; m0_wdata = 0; m0_req = 1;
    bus_readData = 32'hDEADBEEF;
    pushBus(0, 32'h10, 0);
    pushDone(0, r + 2, 32'hDEADBEEF, 0, 32'h10);
    masterWait(0, 1);
    repeat (2) @(posedge clk);

    // Single m1 write, rdata must not move
    #1;
    r = cyc;
    m1_we = 1; m1_addr = 32'h4000_0000; m1_wdata = 32'h1234; m1_req = 1;
    bus_readData = 32'hCAFEF00D;
    pushBus(1, 32'h4000_0000, 32'h1234);
    pushDone(1, r + 2, 32'hDEADBEEF, 0, 32'h4000_0000);
    masterWait(1, 1);
    repeat (2) @(posedge clk);

    // Address change during ACCESS is ignored
    #1;
    r = cyc;
    m0_we = 0; m0_addr = 32'h20; m0_req = 1;
    bus_readData = 32'h55AA55AA;
    pushBus(0, 32'h20, 0);
    pushDone(0, r + 2, 32'h55AA55AA, 0, 32'h20);
    fork
      masterWait(0, 1);
      begin
        @(posedge clk);
        #1 m0_addr = 32'h24;
      end
    join
    repeat (2) @(posedge clk);

    // Reset, then contention from reset
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    resetChecks();
    rst = 1;
    @(posedge clk);
    #1;
    r = cyc;
    m0_we = 0; m0_addr = 32'h100; m0_req = 1;
    m1_we = 1; m1_addr = 32'h200; m1_wdata = 32'hABCD; m1_req = 1;
    bus_readData = 32'h11112222;
    pushBus(0, 32'h100, 0);
    pushBus(1, 32'h200, 32'hABCD);
    pushBus(0, 32'h100, 0);
    pushBus(1, 32'h200, 32'hABCD);
    pushDone(0, r + 2,  32'h11112222, 0, 32'h100);
    pushDone(1, r + 5,  32'h11112222, 0, 32'h200);
    pushDone(0, r + 8,  32'h11112222, 0, 32'h100);
    pushDone(1, r + 11, 32'h11112222, 0, 32'h200);
    fork
      masterWait(0, 2);
      masterWait(1, 2);
    join
    repeat (2) @(posedge clk);

    // Reset abort during ACCESS of an m0 write
    #1;
    m0_we = 1; m0_addr = 32'h300; m0_wdata = 32'h77; m0_req = 1;
    pushBus(1, 32'h300, 32'h77);
    @(posedge clk);
    @(negedge clk);
    #1;
    rst = 0;
    m1_we = 0; m1_addr = 32'h400; m1_req = 1;
    bus_readData = 32'h9999AAAA;
    #1;
    chk("abort_strobe", {62'd0, bus_readEnable, bus_writeEnable}, 64'd0);
    chk("abort_rdata", {32'd0, m0_rdata}, 64'd0);
    chk("abort_grant", {63'd0, grant_id}, 64'd1);
    @(posedge clk);
    @(negedge clk);
    rst = 1;
    r = cyc;
    pushBus(1, 32'h300, 32'h77);
    pushBus(0, 32'h400, 0);
    pushDone(0, r + 2, 0, 0, 32'h300);
    pushDone(1, r + 5, 0, 32'h9999AAAA, 32'h400);
    fork
      masterWait(0, 1);
      masterWait(1, 1);
    join
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("busQ_empty", 64'(busQ.size()), 64'd0);
    chk("doneQ_empty", 64'(doneQ.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
